// File: rtl/cdm_errstat_pkg.sv
// Shared definitions for the cdm16_err_stat error-statistics collector.
// - state_e   : run-control FSM states.
// - DRAIN_CYC : cycles spent flushing the ED pipeline after the last accept.
// - sat_add / add_ovf : saturating unsigned add at a run-time width w (w <= SAT_MAX_W).
// Optional feature macro used by the importing files: CDM_ERRSTAT_SQERR_EN.
package cdm_errstat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Must equal the depth of cdm_ed_pipe.
  localparam int unsigned DRAIN_CYC = 2;

  // Widest accumulator any caller may saturate (covers 2*ACC_W for the squared sum).
  localparam int unsigned SAT_MAX_W = 128;

  // a and b must already fit in w bits; result is clamped to 2**w-1.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int unsigned         w);
    logic [SAT_MAX_W:0]   full;
    logic [SAT_MAX_W-1:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return (full > {1'b0, lim}) ? lim : full[SAT_MAX_W-1:0];
  endfunction

  // True when a + b does not fit in w bits.
  function automatic logic add_ovf(input logic [SAT_MAX_W-1:0] a,
                                   input logic [SAT_MAX_W-1:0] b,
                                   input int unsigned         w);
    logic [SAT_MAX_W:0]   full;
    logic [SAT_MAX_W-1:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return full > {1'b0, lim};
  endfunction

endpackage

// File: rtl/cdm_ed_pipe.sv
// Two-stage exact-product / error-distance pipeline.
// Stage 1 registers the exact product a*b and the approximate product r.
// Stage 2 registers ED = |a*b - r| and ED != 0 (and ED*ED when CDM_ERRSTAT_SQERR_EN).
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : drop every in-flight sample (valids cleared)
//   in_valid_i       : a_i/b_i/r_i carry an accepted sample
//   a_i, b_i, r_i    : operands and approximate product
//   out_valid_o      : ed_o/ed_nz_o (/ed_sq_o) are valid this cycle
//   ed_o, ed_nz_o    : error distance and its non-zero flag
//   ed_sq_o          : ED squared (only with CDM_ERRSTAT_SQERR_EN)
module cdm_ed_pipe #(
  parameter int unsigned OP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic [2*OP_W-1:0] r_i,
  output logic              out_valid_o,
  output logic [2*OP_W-1:0] ed_o,
  output logic              ed_nz_o
`ifdef CDM_ERRSTAT_SQERR_EN
  ,
  output logic [4*OP_W-1:0] ed_sq_o
`endif
);

  localparam int unsigned PW = 2 * OP_W;

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [PW-1:0] prod_q, prod_d, r_q, r_d;
  logic [PW-1:0] ed_q, ed_d;
  logic          nz_q, nz_d;
`ifdef CDM_ERRSTAT_SQERR_EN
  logic [2*PW-1:0] sq_q, sq_d;
`endif

  always_comb begin
    v1_d   = in_valid_i && !flush_i;
    prod_d = PW'(a_i) * PW'(b_i);
    r_d    = r_i;
    v2_d   = v1_q && !flush_i;
    ed_d   = (prod_q >= r_q) ? (prod_q - r_q) : (r_q - prod_q);
    nz_d   = (ed_d != '0);
`ifdef CDM_ERRSTAT_SQERR_EN
    sq_d   = (2*PW)'(ed_d) * (2*PW)'(ed_d);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      r_q    <= '0;
      ed_q   <= '0;
      nz_q   <= 1'b0;
`ifdef CDM_ERRSTAT_SQERR_EN
      sq_q   <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      prod_q <= prod_d;
      r_q    <= r_d;
      ed_q   <= ed_d;
      nz_q   <= nz_d;
`ifdef CDM_ERRSTAT_SQERR_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign out_valid_o = v2_q;
  assign ed_o        = ed_q;
  assign ed_nz_o     = nz_q;
`ifdef CDM_ERRSTAT_SQERR_EN
  assign ed_sq_o     = sq_q;
`endif

endmodule

// File: rtl/cdm16_err_stat.sv
// Error-statistics collector for the 16x16 carry-disregard approximate multiplier.
// Accepts (A, B, R), recomputes A*B exactly, and accumulates over num_samples samples:
// count, error count (ED != 0), saturating ED sum, max ED, sticky overflow.
// Optional feature macro: CDM_ERRSTAT_SQERR_EN adds ed_sq_sum (saturating sum of ED^2).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, num_samples  : clear stats, latch run length, begin run
//   in_valid, in_ready  : sample handshake; in_ready = RUN && !start
//   A, B, R             : operands and approximate product
//   busy, done          : run in progress / statistics final
//   sample_cnt, err_cnt, ed_sum, ed_max, ovf (, ed_sq_sum) : statistics
module cdm16_err_stat
  import cdm_errstat_pkg::*;
#(
  parameter int unsigned OP_W  = 16,
  parameter int unsigned ACC_W = 56,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    A,
  input  logic [OP_W-1:0]    B,
  input  logic [2*OP_W-1:0]  R,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   ed_sum,
  output logic [2*OP_W-1:0]  ed_max,
  output logic               ovf
`ifdef CDM_ERRSTAT_SQERR_EN
  ,
  output logic [2*ACC_W-1:0] ed_sq_sum
`endif
);

  state_e               state_q, state_d;
  logic [1:0]           drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]     ed_sum_q, ed_sum_d;
  logic [2*OP_W-1:0]    ed_max_q, ed_max_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef CDM_ERRSTAT_SQERR_EN
  logic [2*ACC_W-1:0]   sq_sum_q, sq_sum_d;
  logic [4*OP_W-1:0]    pipe_sq;
`endif

  logic                 accept;
  logic                 last_accept;
  logic                 pipe_valid;
  logic [2*OP_W-1:0]    pipe_ed;
  logic                 pipe_nz;

  assign in_ready    = (state_q == StRun) && !start;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((sample_cnt_q + CNT_W'(1)) == num_q);

  // start also flushes the pipe so samples from an aborted run never reach the stats.
  cdm_ed_pipe #(
    .OP_W(OP_W)
  ) u_ed_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (start),
    .in_valid_i (accept),
    .a_i        (A),
    .b_i        (B),
    .r_i        (R),
    .out_valid_o(pipe_valid),
    .ed_o       (pipe_ed),
    .ed_nz_o    (pipe_nz)
`ifdef CDM_ERRSTAT_SQERR_EN
    ,
    .ed_sq_o    (pipe_sq)
`endif
  );

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    num_d        = num_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_sum_d     = ed_sum_q;
    ed_max_d     = ed_max_q;
    ovf_d        = ovf_q;
`ifdef CDM_ERRSTAT_SQERR_EN
    sq_sum_d     = sq_sum_q;
`endif

    if (start) begin
      // Restart from any state; a zero-length run completes immediately.
      num_d        = num_samples;
      drain_cnt_d  = '0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_sum_d     = '0;
      ed_max_d     = '0;
      ovf_d        = 1'b0;
`ifdef CDM_ERRSTAT_SQERR_EN
      sq_sum_d     = '0;
`endif
      state_d      = (num_samples == '0) ? StDone : StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (last_accept) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
        StDrain: begin
          if (drain_cnt_q == 2'(DRAIN_CYC - 1)) begin
            state_d = StDone;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase

      if (accept) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end

      if (pipe_valid) begin
        if (pipe_nz && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        ed_sum_d = ACC_W'(sat_add(SAT_MAX_W'(ed_sum_q), SAT_MAX_W'(pipe_ed), ACC_W));
        if (add_ovf(SAT_MAX_W'(ed_sum_q), SAT_MAX_W'(pipe_ed), ACC_W)) begin
          ovf_d = 1'b1;
        end
        if (pipe_ed > ed_max_q) begin
          ed_max_d = pipe_ed;
        end
`ifdef CDM_ERRSTAT_SQERR_EN
        sq_sum_d = (2*ACC_W)'(sat_add(SAT_MAX_W'(sq_sum_q), SAT_MAX_W'(pipe_sq), 2 * ACC_W));
        if (add_ovf(SAT_MAX_W'(sq_sum_q), SAT_MAX_W'(pipe_sq), 2 * ACC_W)) begin
          ovf_d = 1'b1;
        end
`endif
      end
    end

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      drain_cnt_q  <= '0;
      num_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CDM_ERRSTAT_SQERR_EN
      sq_sum_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      num_q        <= num_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_sum_q     <= ed_sum_d;
      ed_max_q     <= ed_max_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CDM_ERRSTAT_SQERR_EN
      sq_sum_q     <= sq_sum_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;
  assign ovf        = ovf_q;
`ifdef CDM_ERRSTAT_SQERR_EN
  assign ed_sq_sum  = sq_sum_q;
`endif

endmodule

// File: tb/tb_cdm16_err_stat.sv
// Self-checking bench for cdm16_err_stat. Two instances share stimulus: the default
// ACC_W=56 build and an ACC_W=8 build that exercises ed_sum saturation.
module tb_cdm16_err_stat;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned ACC_W = 56;
  localparam int unsigned ACC_S = 8;
  localparam int unsigned CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [CNT_W-1:0]  num_samples;
  logic [OP_W-1:0]   A, B;
  logic [2*OP_W-1:0] R;

  logic              a_in_ready, a_busy, a_done, a_ovf;
  logic [CNT_W-1:0]  a_sample_cnt, a_err_cnt;
  logic [ACC_W-1:0]  a_ed_sum;
  logic [2*OP_W-1:0] a_ed_max;
  logic              s_in_ready, s_busy, s_done, s_ovf;
  logic [CNT_W-1:0]  s_sample_cnt, s_err_cnt;
  logic [ACC_S-1:0]  s_ed_sum;
  logic [2*OP_W-1:0] s_ed_max;
`ifdef CDM_ERRSTAT_SQERR_EN
  logic [2*ACC_W-1:0] a_ed_sq_sum;
  logic [2*ACC_S-1:0] s_ed_sq_sum;
`endif

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdm16_err_stat #(.OP_W(OP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(a_in_ready), .A(A), .B(B), .R(R),
    .busy(a_busy), .done(a_done), .sample_cnt(a_sample_cnt), .err_cnt(a_err_cnt),
    .ed_sum(a_ed_sum), .ed_max(a_ed_max), .ovf(a_ovf)
`ifdef CDM_ERRSTAT_SQERR_EN
    , .ed_sq_sum(a_ed_sq_sum)
`endif
  );

  cdm16_err_stat #(.OP_W(OP_W), .ACC_W(ACC_S), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .A(A), .B(B), .R(R),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .ed_sum(s_ed_sum), .ed_max(s_ed_max), .ovf(s_ovf)
`ifdef CDM_ERRSTAT_SQERR_EN
    , .ed_sq_sum(s_ed_sq_sum)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Current run: its length and every accepted sample (accept cycle, ED).
  bit          run_valid = 1'b0;
  int unsigned run_n = 0;
  int unsigned acc_t[$];
  logic [31:0] acc_ed[$];

  typedef struct packed {
    logic         in_ready;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [127:0] scnt;
    logic [127:0] ecnt;
    logic [127:0] sum;
    logic [127:0] max;
    logic [127:0] sq;
  } exp_t;

  function automatic logic [31:0] ed_of(input logic [15:0] a, input logic [15:0] b,
                                        input logic [31:0] r);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return (p > r) ? p - r : r - p;
  endfunction

  // Outputs in cycle n: a sample accepted in cycle t counts in sample_cnt from t+1 and
  // in the ED statistics from t+3; done from t_last+3.
  function automatic exp_t model(input int unsigned n, input int unsigned accw,
                                 input logic start_now);
    exp_t         e;
    int unsigned  cnt;
    logic [127:0] tot, sqt, lim, sqlim;
    e = '0;
    if (run_valid) begin
      cnt = acc_t.size();
      if (run_n == 0) begin
        e.done = 1'b1;
      end else if (cnt == run_n) begin
        e.done = (n >= acc_t[cnt-1] + 3);
        e.busy = !e.done;
      end else begin
        e.busy     = 1'b1;
        e.in_ready = !start_now;
      end
      e.scnt = 128'(cnt);
      tot = '0;
      sqt = '0;
      foreach (acc_t[i]) begin
        if (acc_t[i] + 3 <= n) begin
          if (acc_ed[i] != 0) e.ecnt = e.ecnt + 1;
          tot = tot + 128'(acc_ed[i]);
          sqt = sqt + 128'(acc_ed[i]) * 128'(acc_ed[i]);
          if (128'(acc_ed[i]) > e.max) e.max = 128'(acc_ed[i]);
        end
      end
      lim   = (128'(1) << accw) - 1;
      sqlim = (128'(1) << (2 * accw)) - 1;
      e.ovf = tot > lim;
      e.sum = e.ovf ? lim : tot;
`ifdef CDM_ERRSTAT_SQERR_EN
      if (sqt > sqlim) e.ovf = 1'b1;
      e.sq = (sqt > sqlim) ? sqlim : sqt;
`endif
    end
    return e;
  endfunction

  exp_t ea, es;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      ea = model(cyc, ACC_W, start);
      es = model(cyc, ACC_S, start);
      chk("a.in_ready", a_in_ready, ea.in_ready);
      chk("a.busy", a_busy, ea.busy);
      chk("a.done", a_done, ea.done);
      chk("a.sample_cnt", a_sample_cnt, ea.scnt);
      chk("a.err_cnt", a_err_cnt, ea.ecnt);
      chk("a.ed_sum", a_ed_sum, ea.sum);
      chk("a.ed_max", a_ed_max, ea.max);
      chk("a.ovf", a_ovf, ea.ovf);
      chk("s.in_ready", s_in_ready, es.in_ready);
      chk("s.busy", s_busy, es.busy);
      chk("s.done", s_done, es.done);
      chk("s.sample_cnt", s_sample_cnt, es.scnt);
      chk("s.err_cnt", s_err_cnt, es.ecnt);
      chk("s.ed_sum", s_ed_sum, es.sum);
      chk("s.ed_max", s_ed_max, es.max);
      chk("s.ovf", s_ovf, es.ovf);
`ifdef CDM_ERRSTAT_SQERR_EN
      chk("a.ed_sq_sum", a_ed_sq_sum, ea.sq);
      chk("s.ed_sq_sum", s_ed_sq_sum, es.sq);
`endif
      // Fold this cycle's events into the model.
      if (rst) begin
        run_valid = 1'b0;
        acc_t.delete();
        acc_ed.delete();
      end else if (start) begin
        run_valid = 1'b1;
        run_n     = num_samples;
        acc_t.delete();
        acc_ed.delete();
      end else if (in_valid && ea.in_ready) begin
        acc_t.push_back(cyc);
        acc_ed.push_back(ed_of(A, B, R));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] r,
                      output int unsigned t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = 0;
    A = a;
    B = b;
    R = r;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        t_acc = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cycle=%0d got=no_accept want=accept", cyc);
    end
  endtask

  task automatic wait_done(output int unsigned t_done);
    bit seen;
    seen = 1'b0;
    t_done = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (a_done) begin
        seen = 1'b1;
        t_done = cyc;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout cycle=%0d got=0 want=1", cyc);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t_acc, t_done;
    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    R = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("lit.reset.busy", a_busy, 0);
    chk("lit.reset.done", a_done, 0);
    chk("lit.reset.in_ready", a_in_ready, 0);
    chk("lit.reset.ed_sum", a_ed_sum, 0);
    tick();

    // Exact products only.
    do_start(3);
    send(16'd3, 16'd5, 32'd15, t_acc);
    send(16'd7, 16'd9, 32'd63, t_acc);
    send(16'd0, 16'd0, 32'd0, t_acc);
    wait_done(t_done);
    chk("lit.t1.sample_cnt", a_sample_cnt, 3);
    chk("lit.t1.err_cnt", a_err_cnt, 0);
    chk("lit.t1.ed_sum", a_ed_sum, 0);
    chk("lit.t1.ed_max", a_ed_max, 0);

    // ED=1 (R below exact) then ED=6 (R above exact).
    do_start(2);
    send(16'hFFFF, 16'hFFFF, 32'hFFFE0000, t_acc);
    send(16'd2, 16'd2, 32'd10, t_acc);
    wait_done(t_done);
    chk("lit.t2.done_latency", t_done - t_acc, 3);
    chk("lit.t2.err_cnt", a_err_cnt, 2);
    chk("lit.t2.ed_sum", a_ed_sum, 7);
    chk("lit.t2.ed_max", a_ed_max, 6);
    chk("lit.t2.s_ed_sum", s_ed_sum, 7);

    // Zero-length run.
    do_start(0);
    @(negedge clk);
    chk("lit.t3.done", a_done, 1);
    chk("lit.t3.in_ready", a_in_ready, 0);
    chk("lit.t3.sample_cnt", a_sample_cnt, 0);
    repeat (3) tick();

    // Saturation in the 8-bit accumulator.
    do_start(2);
    send(16'd1, 16'd0, 32'd200, t_acc);
    send(16'd1, 16'd0, 32'd200, t_acc);
    wait_done(t_done);
    chk("lit.t4.s_ed_sum", s_ed_sum, 255);
    chk("lit.t4.s_ovf", s_ovf, 1);
    chk("lit.t4.s_ed_max", s_ed_max, 200);
    chk("lit.t4.a_ed_sum", a_ed_sum, 400);
    chk("lit.t4.a_ovf", a_ovf, 0);

    // Restart while samples are in flight.
    do_start(5);
    send(16'd5, 16'd5, 32'd0, t_acc);
    send(16'd6, 16'd6, 32'd0, t_acc);
    do_start(1);
    send(16'd1, 16'd0, 32'd4, t_acc);
    wait_done(t_done);
    chk("lit.t5.sample_cnt", a_sample_cnt, 1);
    chk("lit.t5.ed_sum", a_ed_sum, 4);
    chk("lit.t5.ed_max", a_ed_max, 4);

    // Reset during DRAIN, then a normal run.
    do_start(3);
    send(16'd2, 16'd3, 32'd1, t_acc);
    send(16'd2, 16'd3, 32'd1, t_acc);
    send(16'd2, 16'd3, 32'd1, t_acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("lit.t6.busy", a_busy, 0);
    chk("lit.t6.done", a_done, 0);
    chk("lit.t6.sample_cnt", a_sample_cnt, 0);
    chk("lit.t6.ed_sum", a_ed_sum, 0);
    tick();
    do_start(1);
    send(16'd4, 16'd4, 32'd20, t_acc);
    wait_done(t_done);
    chk("lit.t6.err_cnt", a_err_cnt, 1);
    chk("lit.t6.ed_sum2", a_ed_sum, 4);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
